// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch control states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  // Width of a counter that must hold values 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sync_fifo
//  Description : Small synchronous FIFO with clear, occupancy count and a
//                combinational head (zero when empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO at once
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because head is masked when empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch control. Owns the fetch PC, issues word
//                requests to instruction memory, pairs returned words with
//                their PC for decode, and discards old-path responses after
//                a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [ADDR_W-1:0]  pc_out
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  MAX_CNT      = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_W-1:0] WORD_MASK    = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] BOOT_PC      = RESET_PC & WORD_MASK;
  localparam logic [ADDR_W-1:0] PC_INCREMENT = ADDR_W'(4);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  drop_next;
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W-1:0]  pcq_count;
  logic [CNT_W-1:0]  dq_count;
  logic              req_fire;
  logic              resp_push;
  logic              out_fire;

  // PC queue: address of every issued request, in issue order
  fetch_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (out_fire),
    .clear (redirect_valid),
    .din   (pc),
    .head  (pc_out),
    .count (pcq_count)
  );

  // Data queue: returned instruction words awaiting decode
  fetch_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_dq (
    .clk   (clk),
    .reset (reset),
    .push  (resp_push),
    .pop   (out_fire),
    .clear (redirect_valid),
    .din   (imem_resp_data),
    .head  (instruction_out),
    .count (dq_count)
  );

  assign imem_req_addr = pc;

  // Handshake qualification; a redirect suppresses issue, delivery and capture
  always_comb begin
    imem_req_valid = (state == ST_RUN) && !redirect_valid && (pcq_count < MAX_CNT);
    out_valid      = (dq_count != '0) && !redirect_valid;
    req_fire       = imem_req_valid && imem_req_ready;
    out_fire       = out_valid && out_ready;
    resp_push      = imem_resp_valid && (state == ST_RUN) && !redirect_valid;
  end

  // Next-state, next-PC and drop-count computation
  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop_next  = drop_cnt;
    in_flight  = (pcq_count > dq_count) ? (pcq_count - dq_count) : '0;

    if (redirect_valid) begin
      pc_next = redirect_pc & WORD_MASK;
      case (state)
        ST_RUN: begin
          // A response landing this cycle belongs to the old path as well
          drop_next = (imem_resp_valid && (in_flight != '0)) ? (in_flight - 1'b1) : in_flight;
        end
        ST_FLUSH: begin
          drop_next = (imem_resp_valid && (drop_cnt != '0)) ? (drop_cnt - 1'b1) : drop_cnt;
        end
        default: begin
          drop_next = '0;
        end
      endcase
      state_next = (drop_next != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      if (req_fire) pc_next = pc + PC_INCREMENT;
      case (state)
        ST_BOOT: begin
          state_next = ST_RUN;
        end
        ST_RUN: begin
          state_next = ST_RUN;
        end
        ST_FLUSH: begin
          if (imem_resp_valid && (drop_cnt != '0)) begin
            drop_next = drop_cnt - 1'b1;
            if (drop_cnt == CNT_W'(1)) state_next = ST_RUN;
          end else if (drop_cnt == '0) begin
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_BOOT;
          drop_next  = '0;
        end
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= BOOT_PC;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      drop_cnt <= drop_next;
    end
  end

  // Memory protocol checks: every captured response needs an outstanding slot
  always_ff @(posedge clk) begin
    if (!reset && resp_push) begin
      assert (pcq_count != dq_count)
        else $error("fetch_sequencer: response with no outstanding request");
      assert (dq_count != MAX_CNT)
        else $error("fetch_sequencer: response into a full data queue");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer with a
//                variable-latency in-order instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int lat = 1;
  int req_total = 0;
  int deliv_total = 0;
  int max_out = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] dl_pc[$];
  logic [31:0] dl_ins[$];
  int          dl_cyc[$];

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instruction_out (instruction_out),
    .pc_out          (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    dl_pc.delete();
    dl_ins.delete();
    dl_cyc.delete();
  endtask

  // One clock cycle: sample handshakes mid-cycle, advance, update memory model
  task automatic tick();
    logic        req_hs;
    logic        out_hs;
    logic        resp_now;
    logic [31:0] a;
    logic [31:0] pco;
    logic [31:0] ins;
    #2;
    req_hs   = imem_req_valid && imem_req_ready;
    a        = imem_req_addr;
    out_hs   = out_valid && out_ready;
    pco      = pc_out;
    ins      = instruction_out;
    resp_now = imem_resp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (resp_now && pend_addr.size() != 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (req_hs) begin
        pend_addr.push_back(a);
        pend_due.push_back(cyc + lat - 1);
        req_log.push_back(a);
        req_cyc.push_back(cyc - 1);
        req_total++;
      end
      if (out_hs) begin
        dl_pc.push_back(pco);
        dl_ins.push_back(ins);
        dl_cyc.push_back(cyc - 1);
        deliv_total++;
      end
    end
    if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    if (req_total - deliv_total > max_out) max_out = req_total - deliv_total;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Two reset cycles; on return the current cycle is the BOOT cycle
  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    ticks(2);
    reset = 1'b0;
    clear_logs();
    req_total = 0;
    deliv_total = 0;
    max_out = 0;
  endtask

  initial begin
    // ---------------- reset values and BOOT cycle ----------------
    lat = 1;
    ticks(2);
    check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_instr", instruction_out, 32'h0);
    check_eq("rst_pc_out", pc_out, 32'h0);
    do_reset();
    check_eq("boot_no_req", {31'b0, imem_req_valid}, 32'd0);

    // ---------------- free run, latency 1 ----------------
    ticks(14);
    check_eq("run_req0", q_at(req_log, 0), 32'h0);
    check_eq("run_req1", q_at(req_log, 1), 32'h4);
    check_eq("run_req2", q_at(req_log, 2), 32'h8);
    check_eq("run_req_consec", req_cyc.size() > 1 ? 32'(req_cyc[1] - req_cyc[0]) : 32'hFFFF, 32'd1);
    check_eq("run_lat", (req_cyc.size() > 0 && dl_cyc.size() > 0) ? 32'(dl_cyc[0] - req_cyc[0]) : 32'hFFFF, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check_eq("run_pc_out", q_at(dl_pc, i), 32'(4 * i));
      check_eq("run_instr", q_at(dl_ins, i), mem_word(32'(4 * i)));
    end

    // ---------------- request stall then latency 3 ----------------
    lat = 3;
    do_reset();
    imem_req_ready = 1'b0;
    ticks(2);
    check_eq("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_eq("stall_req_addr", imem_req_addr, 32'h0);
    tick();
    check_eq("stall_addr_held", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    ticks(30);
    check_eq("lat3_max_outstanding", 32'(max_out), 32'd2);
    for (int i = 0; i < 6; i++) begin
      check_eq("lat3_pc_out", q_at(dl_pc, i), 32'(4 * i));
      check_eq("lat3_instr", q_at(dl_ins, i), mem_word(32'(4 * i)));
    end

    // ---------------- decode stall ----------------
    lat = 1;
    do_reset();
    out_ready = 1'b0;
    ticks(4);
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("hold_pc_out", pc_out, 32'h0);
      check_eq("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
      tick();
    end
    check_eq("hold_no_deliv", 32'(dl_pc.size()), 32'd0);
    out_ready = 1'b1;
    ticks(12);
    for (int i = 0; i < 4; i++) check_eq("resume_pc_out", q_at(dl_pc, i), 32'(4 * i));
    check_eq("resume_instr3", q_at(dl_ins, 3), mem_word(32'hC));

    // ---------------- redirect with two requests in flight ----------------
    lat = 3;
    do_reset();
    ticks(3);
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check_eq("redir_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("flush_no_req", {31'b0, imem_req_valid}, 32'd0);
    ticks(14);
    check_eq("redir_first_req", q_at(req_log, 0), 32'h0000_0100);
    check_eq("redir_first_pc", q_at(dl_pc, 0), 32'h0000_0100);
    check_eq("redir_first_instr", q_at(dl_ins, 0), mem_word(32'h100));
    check_eq("redir_second_pc", q_at(dl_pc, 1), 32'h0000_0104);

    // ---------------- redirect with response and pending out ----------------
    lat = 1;
    do_reset();
    ticks(3);
    clear_logs();
    check_eq("same_resp_present", {31'b0, imem_resp_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check_eq("same_out_blocked", {31'b0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("same_no_deliv", 32'(dl_pc.size()), 32'd0);
    check_eq("same_run_req", {31'b0, imem_req_valid}, 32'd1);
    check_eq("same_run_addr", imem_req_addr, 32'h0000_0200);
    ticks(6);
    check_eq("same_first_pc", q_at(dl_pc, 0), 32'h0000_0200);

    // in_flight 2 with a response in the redirect cycle: exactly one drop left
    lat = 2;
    do_reset();
    ticks(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("drop1_flush_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    check_eq("drop1_run_req", {31'b0, imem_req_valid}, 32'd1);
    check_eq("drop1_run_addr", imem_req_addr, 32'h0000_0300);

    // ---------------- PC wrap ----------------
    lat = 1;
    do_reset();
    tick();
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    ticks(8);
    check_eq("wrap_req0", q_at(req_log, 0), 32'hFFFF_FFFC);
    check_eq("wrap_req1", q_at(req_log, 1), 32'h0000_0000);
    check_eq("wrap_pc0", q_at(dl_pc, 0), 32'hFFFF_FFFC);
    check_eq("wrap_pc1", q_at(dl_pc, 1), 32'h0000_0000);

    // ---------------- reset in the middle of FLUSH ----------------
    lat = 3;
    do_reset();
    ticks(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_eq("mid_rst_req_addr", imem_req_addr, 32'h0);
    check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("mid_rst_instr", instruction_out, 32'h0);
    check_eq("mid_rst_pc_out", pc_out, 32'h0);
    reset = 1'b0;
    clear_logs();
    ticks(10);
    check_eq("post_rst_pc0", q_at(dl_pc, 0), 32'h0);
    check_eq("post_rst_instr0", q_at(dl_ins, 0), mem_word(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
